neuron_4in_ctrl: RTL

Sequencing controller for a layer of four `neuron_4in` instances in the ODESA pipeline. On each input event it waits for the synapse traces to settle, picks the winning neuron by largest gated output, and emits a one-cycle spike to that neuron only. It then adapts the per-neuron thresholds and enforces a refractory window before accepting the next event.

---
 rtl/neuron_4in_ctrl.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/neuron_4in_ctrl.sv
// Winner-take-all sequencer for a layer of four neuron_4in instances: settle, compare, spike,
// adapt thresholds, refractory wait. Define NEURON_CTRL_DECAY_EN to enable threshold decay.
module neuron_4in_ctrl #(
    parameter int unsigned p_input_width    = 9,
    parameter int unsigned p_weight_width   = 9,
    parameter int unsigned p_th_init        = 100,
    parameter int unsigned p_eta_shift      = 2,
    parameter int unsigned p_th_dec         = 1,
    parameter int unsigned p_th_min         = 16,
    parameter int unsigned p_settle_cycles  = 2,
    parameter int unsigned p_refract_cycles = 4,
    localparam int unsigned W = p_input_width + p_weight_width + 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_event_valid,
    input  logic [W-1:0] i_neuron_out_1,
    input  logic [W-1:0] i_neuron_out_2,
    input  logic [W-1:0] i_neuron_out_3,
    input  logic [W-1:0] i_neuron_out_4,
    input  logic [W-1:0] i_lv_1,
    input  logic [W-1:0] i_lv_2,
    input  logic [W-1:0] i_lv_3,
    input  logic [W-1:0] i_lv_4,
    output logic [W-1:0] o_threshold_1,
    output logic [W-1:0] o_threshold_2,
    output logic [W-1:0] o_threshold_3,
    output logic [W-1:0] o_threshold_4,
    output logic [3:0]   o_spike,
    output logic [1:0]   o_winner,
    output logic         o_fired,
    output logic         o_valid,
    output logic         o_busy,
    output logic [7:0]   o_drop_cnt
);

    localparam int unsigned CntMax = (p_settle_cycles > p_refract_cycles) ?
                                     p_settle_cycles : p_refract_cycles;
    localparam int unsigned CntW = $clog2(CntMax + 1);
    localparam logic [W-1:0] ThInit = W'(p_th_init);

    typedef enum logic [2:0] {
        StIdle, StSettle, StCompare, StFire, StAdapt, StRefract
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [1:0]        winner_q, winner_d;
    logic              fired_q, fired_d;
    logic [3:0]        spike_q, spike_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic [7:0]        drop_q, drop_d;
    logic [W-1:0]      th_q [4];
    logic [W-1:0]      th_d [4];

    logic [W-1:0]      nout [4];
    logic [W-1:0]      lv [4];
    logic [W-1:0]      best_val;
    logic [1:0]        best_idx;
    logic              found;
    logic [W-1:0]      th_win, lv_win, th_adapt;

    assign nout[0] = i_neuron_out_1;
    assign nout[1] = i_neuron_out_2;
    assign nout[2] = i_neuron_out_3;
    assign nout[3] = i_neuron_out_4;
    assign lv[0]   = i_lv_1;
    assign lv[1]   = i_lv_2;
    assign lv[2]   = i_lv_3;
    assign lv[3]   = i_lv_4;

    // Strict compare keeps the lowest index on ties; zero outputs never win.
    always_comb begin
        best_val = '0;
        best_idx = '0;
        for (int i = 0; i < 4; i++) begin
            if (nout[i] > best_val) begin
                best_val = nout[i];
                best_idx = 2'(i);
            end
        end
    end
    assign found = (best_val != '0);

    always_comb begin
        th_win = th_q[winner_q];
        lv_win = lv[winner_q];
        if (lv_win >= th_win) begin
            th_adapt = th_win + ((lv_win - th_win) >> p_eta_shift);
        end else begin
            th_adapt = th_win - ((th_win - lv_win) >> p_eta_shift);
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        winner_d = winner_q;
        fired_d  = fired_q;
        spike_d  = '0;
        valid_d  = 1'b0;
        drop_d   = drop_q;
        th_d     = th_q;

        if (i_event_valid && (state_q != StIdle) && (drop_q != 8'hff)) begin
            drop_d = drop_q + 8'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (i_event_valid) begin
                    state_d = StSettle;
                    cnt_d   = CntW'(p_settle_cycles);
                end
            end
            StSettle: begin
                if (cnt_q <= CntW'(1)) begin
                    state_d = StCompare;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StCompare: begin
                winner_d = best_idx;
                fired_d  = found;
                if (found) begin
                    spike_d = 4'b0001 << best_idx;
                    state_d = StFire;
                end else begin
                    state_d = StAdapt;
                end
            end
            StFire: begin
                state_d = StAdapt;
            end
            StAdapt: begin
                valid_d = 1'b1;
                if (fired_q) begin
                    th_d[winner_q] = th_adapt;
                    if (p_refract_cycles == 0) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StRefract;
                        cnt_d   = CntW'(p_refract_cycles);
                    end
                end else begin
`ifdef NEURON_CTRL_DECAY_EN
                    for (int i = 0; i < 4; i++) begin
                        if (th_q[i] >= W'(p_th_min)) begin
                            if ((th_q[i] - W'(p_th_min)) < W'(p_th_dec)) begin
                                th_d[i] = W'(p_th_min);
                            end else begin
                                th_d[i] = th_q[i] - W'(p_th_dec);
                            end
                        end
                    end
`else
                    th_d = th_q;
`endif
                    state_d = StIdle;
                end
            end
            StRefract: begin
                if (cnt_q <= CntW'(1)) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            winner_q <= '0;
            fired_q  <= 1'b0;
            spike_q  <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            drop_q   <= '0;
            for (int i = 0; i < 4; i++) begin
                th_q[i] <= ThInit;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            winner_q <= winner_d;
            fired_q  <= fired_d;
            spike_q  <= spike_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            drop_q   <= drop_d;
            th_q     <= th_d;
        end
    end

    assign o_threshold_1 = th_q[0];
    assign o_threshold_2 = th_q[1];
    assign o_threshold_3 = th_q[2];
    assign o_threshold_4 = th_q[3];
    assign o_spike       = spike_q;
    assign o_winner      = winner_q;
    assign o_fired       = fired_q;
    assign o_valid       = valid_q;
    assign o_busy        = busy_q;
    assign o_drop_cnt    = drop_q;

endmodule
